// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: shares one LAT-cycle pipelined 32-bit barrel shifter
// between two requesters and routes each result back to its issuer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          request handshake per requester (N = 0, 1)
//   reqN_data/amt/dir         operand, shift amount, direction (1 = right)
//   sh_valid/data/amt/dir     registered issue port into the shifter
//   sh_result                 shifter output, valid LAT cycles after issue
//   rspN_valid                one-cycle result strobe per requester
//   rsp_data                  shared result bus (pass-through of sh_result)
//   busy                      any operation issued but not yet returned
//
// Build option: define BSA_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority and no pointer is built.

module barrel_shift_arbiter #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_amt,
  input  logic        req0_dir,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_amt,
  input  logic        req1_dir,
  output logic        sh_valid,
  output logic [31:0] sh_data,
  output logic [4:0]  sh_amt,
  output logic        sh_dir,
  input  logic [31:0] sh_result,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        busy
);

  logic grant0;
  logic grant1;
  logic sh_id;

  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;

`ifdef BSA_ROUND_ROBIN_EN
  // last = id of the most recent grant; the other side wins a tie.
  logic last;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || last)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (grant0) begin
      last <= 1'b0;
    end else if (grant1) begin
      last <= 1'b1;
    end
  end
`else
  always_comb begin
    grant0 = !rst && req0_valid;
    grant1 = !rst && req1_valid && !req0_valid;
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Issue register: operands hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_valid <= 1'b0;
      sh_data  <= '0;
      sh_amt   <= '0;
      sh_dir   <= 1'b0;
      sh_id    <= 1'b0;
    end else if (grant0) begin
      sh_valid <= 1'b1;
      sh_data  <= req0_data;
      sh_amt   <= req0_amt;
      sh_dir   <= req0_dir;
      sh_id    <= 1'b0;
    end else if (grant1) begin
      sh_valid <= 1'b1;
      sh_data  <= req1_data;
      sh_amt   <= req1_amt;
      sh_dir   <= req1_dir;
      sh_id    <= 1'b1;
    end else begin
      sh_valid <= 1'b0;
    end
  end

  // Tag pipeline mirrors the shifter: entry LAT-1 lines up with sh_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= sh_valid;
      tag_id[0] <= sh_id;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rsp0_valid = tag_v[LAT-1] & ~tag_id[LAT-1];
  assign rsp1_valid = tag_v[LAT-1] &  tag_id[LAT-1];
  assign rsp_data   = sh_result;
  assign busy       = sh_valid | (|tag_v);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb_barrel_shift_arbiter: directed + random stimulus against a
// transaction-level scoreboard of the shared shifter arbiter.

module tb_barrel_shift_arbiter;

  localparam int LAT = 5;

`ifdef BSA_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_data;
  logic [4:0]  req0_amt;
  logic        req0_dir;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_data;
  logic [4:0]  req1_amt;
  logic        req1_dir;
  logic        sh_valid;
  logic [31:0] sh_data;
  logic [4:0]  sh_amt;
  logic        sh_dir;
  logic [31:0] sh_result;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
  logic        busy;

  barrel_shift_arbiter #(.LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_dir   (req0_dir),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_dir   (req1_dir),
    .sh_valid   (sh_valid),
    .sh_data    (sh_data),
    .sh_amt     (sh_amt),
    .sh_dir     (sh_dir),
    .sh_result  (sh_result),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external shifter: LAT-cycle pipeline.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= sh_dir ? (sh_data >> sh_amt) : (sh_data << sh_amt);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sh_result = pipe[LAT-1];

  typedef struct {
    bit          id;
    logic [31:0] res;
    int          due;
  } flight_t;

  flight_t     q[$];
  int          cyc;
  int          last_id;
  bit          model_ok;
  bit          e_sh_valid;
  logic [31:0] e_sh_data;
  logic [4:0]  e_sh_amt;
  bit          e_sh_dir;
  int          checks;
  int          passed;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s cycle %0d: observed %h expected %h",
                tag, cyc, obs, exp);
  endtask

  // One clock cycle: drive, check mid-cycle, advance model at the edge.
  task automatic step(input bit r,
                      input bit v0, input logic [31:0] d0,
                      input logic [4:0] a0, input bit di0,
                      input bit v1, input logic [31:0] d1,
                      input logic [4:0] a1, input bit di1);
    int          gid;
    bit          e0;
    bit          e1;
    bit          eb;
    logic [31:0] ed;
    rst = r;
    req0_valid = v0; req0_data = d0; req0_amt = a0; req0_dir = di0;
    req1_valid = v1; req1_data = d1; req1_amt = a1; req1_dir = di1;
    #1;
    gid = -1;
    if (!r) begin
      if (v0 && v1) gid = RR ? ((last_id == 0) ? 1 : 0) : 0;
      else if (v0) gid = 0;
      else if (v1) gid = 1;
    end
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, gid == 0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, gid == 1});
    if (model_ok) begin
      e0 = 0; e1 = 0; eb = 0; ed = '0;
      foreach (q[i]) begin
        if (q[i].due == cyc) begin
          e0 = (q[i].id == 0);
          e1 = (q[i].id == 1);
          ed = q[i].res;
        end
        if (cyc >= q[i].due - LAT && cyc <= q[i].due) eb = 1;
      end
      chk("sh_valid", {31'd0, sh_valid}, {31'd0, e_sh_valid});
      chk("sh_data", sh_data, e_sh_data);
      chk("sh_amt", {27'd0, sh_amt}, {27'd0, e_sh_amt});
      chk("sh_dir", {31'd0, sh_dir}, {31'd0, e_sh_dir});
      chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, e0});
      chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e1});
      chk("busy", {31'd0, busy}, {31'd0, eb});
      if (e0 || e1) chk("rsp_data", rsp_data, ed);
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      last_id = 1;
      e_sh_valid = 0; e_sh_data = '0; e_sh_amt = '0; e_sh_dir = 0;
      model_ok = 1;
    end else begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].due <= cyc) q.delete(i);
      e_sh_valid = (gid >= 0);
      if (gid >= 0) begin
        flight_t f;
        f.id  = (gid == 1);
        f.due = cyc + 1 + LAT;
        if (gid == 0) begin
          f.res = di0 ? (d0 >> a0) : (d0 << a0);
          e_sh_data = d0; e_sh_amt = a0; e_sh_dir = di0;
        end else begin
          f.res = di1 ? (d1 >> a1) : (d1 << a1);
          e_sh_data = d1; e_sh_amt = a1; e_sh_dir = di1;
        end
        q.push_back(f);
        last_id = gid;
      end
    end
    cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    checks = 0; passed = 0; cyc = 0; last_id = 1; model_ok = 0;
    e_sh_valid = 0; e_sh_data = '0; e_sh_amt = '0; e_sh_dir = 0;

    // Reset, then single request accepted at cycle 10.
    for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 0, 0, '0, '0, 0);
    idle(7);
    step(0, 1, 32'h0000_0001, 5'd4, 0, 0, '0, '0, 0);
    idle(9);

    // Contention for 6 cycles, then requester 0 drops.
    for (int i = 0; i < 6; i++)
      step(0, 1, 32'h0000_0100 + i, 5'(i + 1), 0,
              1, 32'hF000_0000 - i, 5'(i + 2), 1);
    step(0, 0, '0, '0, 0, 1, 32'h1234_5678, 5'd8, 1);
    idle(10);

    // Reset with three operations in flight.
    step(0, 1, 32'hAAAA_5555, 5'd3, 0, 0, '0, '0, 0);
    step(0, 0, '0, '0, 0, 1, 32'h5555_AAAA, 5'd7, 1);
    step(0, 1, 32'hDEAD_BEEF, 5'd0, 1, 0, '0, '0, 0);
    step(1, 0, '0, '0, 0, 0, '0, '0, 0);
    idle(10);

    // Requester 1 accept in the same cycle requester 0's result returns.
    step(0, 1, 32'h0000_00F0, 5'd2, 1, 0, '0, '0, 0);
    idle(LAT);
    step(0, 0, '0, '0, 0, 1, 32'h8000_0000, 5'd31, 1);
    idle(LAT + 3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0, $urandom,
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, $urandom,
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    idle(LAT + 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
